// File: rtl/demosaic_pkg.sv
// Shared definitions for the demosaic pixel-SRAM arbiter: frame geometry,
// arbiter state encoding, master identifiers and channel lane indices.
package demosaic_pkg;

    // 128x128 frame, one byte per colour channel
    localparam int PIX_ADDR_W    = 14;
    localparam int PIX_DATA_W    = 8;
    localparam int ARB_MAX_BURST = 16;

    // Arbiter ownership states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Master identifier: 0 = demosaic engine, 1 = frame loader / host readout
    typedef logic master_id_t;

    localparam master_id_t MID_M0 = 1'b0;
    localparam master_id_t MID_M1 = 1'b1;

    // Lane positions inside {r,g,b} words and the 3-bit byte enable
    localparam int CH_R = 2;
    localparam int CH_G = 1;
    localparam int CH_B = 0;

endpackage

// File: rtl/demosaic_arb_rd_tag.sv
// Two-stage {valid,id} pipe that follows each accepted read beat through the
// registered address stage and the SRAM access, and raises rvalid for the
// master that issued the read exactly when SRAM data arrives.
module demosaic_arb_rd_tag
    import demosaic_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       rd_beat,
    input  master_id_t beat_id,
    output logic       rvalid0,
    output logic       rvalid1
);

    logic       vld_p0;
    logic       vld_p1;
    master_id_t id_p0;
    master_id_t id_p1;

    // Valid bits: cleared by reset so reads in flight at reset never return
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            // p0: beat accepted, address now registered toward SRAM
            vld_p0 <= rd_beat;
            // p1: SRAM has produced the read word
            vld_p1 <= vld_p0;
        end
    end

    // Owner id rides alongside the valid bits; only meaningful when valid
    always_ff @(posedge clk) begin
        id_p0 <= beat_id;
        id_p1 <= id_p0;
    end

    assign rvalid0 = vld_p1 & (id_p1 == MID_M0);
    assign rvalid1 = vld_p1 & (id_p1 == MID_M1);

endmodule

// File: rtl/demosaic_mem_arbiter.sv
// Round-robin arbiter sharing the R/G/B pixel SRAM triple between the demosaic
// engine (M0) and the frame loader / host readout (M1). The owner keeps the
// grant for up to MAX_BURST beats while the other master waits, indefinitely
// when the other is idle. Memory-side outputs are registered; read data is
// passed straight through and flagged valid for the issuing master.
module demosaic_mem_arbiter
    import demosaic_pkg::*;
#(
    parameter int ADDR_W    = PIX_ADDR_W,
    parameter int DATA_W    = PIX_DATA_W,
    parameter int MAX_BURST = ARB_MAX_BURST
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  m0_req,
    input  logic                  m0_wr,
    input  logic [2:0]            m0_be,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [3*DATA_W-1:0]   m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [3*DATA_W-1:0]   m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_wr,
    input  logic [2:0]            m1_be,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [3*DATA_W-1:0]   m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [3*DATA_W-1:0]   m1_rdata,

    output logic                  wr_r,
    output logic                  wr_g,
    output logic                  wr_b,
    output logic [ADDR_W-1:0]     addr_r,
    output logic [ADDR_W-1:0]     addr_g,
    output logic [ADDR_W-1:0]     addr_b,
    output logic [DATA_W-1:0]     wdata_r,
    output logic [DATA_W-1:0]     wdata_g,
    output logic [DATA_W-1:0]     wdata_b,
    input  logic [DATA_W-1:0]     rdata_r,
    input  logic [DATA_W-1:0]     rdata_g,
    input  logic [DATA_W-1:0]     rdata_b
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t        state;
    arb_state_t        state_next;
    master_id_t        rr_ptr;
    master_id_t        rr_next;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  cnt_next;

    logic                 beat;
    logic                 sel_wr;
    logic [2:0]           sel_be;
    logic [ADDR_W-1:0]    sel_addr;
    logic [3*DATA_W-1:0]  sel_wdata;
    logic                 rd_beat;
    master_id_t           beat_id;

    // Ownership FSM: grants follow the owner's request combinationally; the
    // burst counter saturates at its last value and only forces a handover
    // when the other master is actually waiting.
    always_comb begin
        state_next = state;
        rr_next    = rr_ptr;
        cnt_next   = beat_cnt;
        m0_gnt     = 1'b0;
        m1_gnt     = 1'b0;
        if (reset) begin
            case (state)
                IDLE: begin
                    if (m0_req && m1_req) begin
                        state_next = (rr_ptr == MID_M1) ? OWN1 : OWN0;
                    end else if (m0_req) begin
                        state_next = OWN0;
                    end else if (m1_req) begin
                        state_next = OWN1;
                    end
                end
                OWN0: begin
                    m0_gnt = m0_req;
                    if (!m0_req || (beat_cnt == CNT_LAST && m1_req)) begin
                        state_next = m1_req ? OWN1 : IDLE;
                        rr_next    = MID_M1;
                        cnt_next   = '0;
                    end else if (beat_cnt != CNT_LAST) begin
                        cnt_next = beat_cnt + CNT_W'(1);
                    end
                end
                OWN1: begin
                    m1_gnt = m1_req;
                    if (!m1_req || (beat_cnt == CNT_LAST && m0_req)) begin
                        state_next = m0_req ? OWN0 : IDLE;
                        rr_next    = MID_M0;
                        cnt_next   = '0;
                    end else if (beat_cnt != CNT_LAST) begin
                        cnt_next = beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Arbiter state, round-robin pointer and burst counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            rr_ptr   <= MID_M0;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            rr_ptr   <= rr_next;
            beat_cnt <= cnt_next;
        end
    end

    // Select the granted master's beat fields; at most one grant is active
    always_comb begin
        sel_wr    = m0_wr;
        sel_be    = m0_be;
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        if (m1_gnt) begin
            sel_wr    = m1_wr;
            sel_be    = m1_be;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
        end
    end

    assign beat    = m0_gnt | m1_gnt;
    assign rd_beat = beat & ~sel_wr;
    assign beat_id = m1_gnt ? MID_M1 : MID_M0;

    // Registered SRAM side: write enables pulse for one cycle per write beat,
    // address and write data hold between beats
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_r    <= 1'b0;
            wr_g    <= 1'b0;
            wr_b    <= 1'b0;
            addr_r  <= '0;
            addr_g  <= '0;
            addr_b  <= '0;
            wdata_r <= '0;
            wdata_g <= '0;
            wdata_b <= '0;
        end else begin
            wr_r <= beat & sel_wr & sel_be[CH_R];
            wr_g <= beat & sel_wr & sel_be[CH_G];
            wr_b <= beat & sel_wr & sel_be[CH_B];
            if (beat) begin
                addr_r  <= sel_addr;
                addr_g  <= sel_addr;
                addr_b  <= sel_addr;
                wdata_r <= sel_wdata[CH_R*DATA_W +: DATA_W];
                wdata_g <= sel_wdata[CH_G*DATA_W +: DATA_W];
                wdata_b <= sel_wdata[CH_B*DATA_W +: DATA_W];
            end
        end
    end

    demosaic_arb_rd_tag u_rd_tag (
        .clk     (clk),
        .reset   (reset),
        .rd_beat (rd_beat),
        .beat_id (beat_id),
        .rvalid0 (m0_rvalid),
        .rvalid1 (m1_rvalid)
    );

    // Reads ignore byte enables: all three channels are returned to both
    // masters, rvalid says whose word it is
    assign m0_rdata = {rdata_r, rdata_g, rdata_b};
    assign m1_rdata = {rdata_r, rdata_g, rdata_b};

endmodule

// File: tb/tb_demosaic_mem_arbiter.sv
// Bench for demosaic_mem_arbiter: behavioural SRAM triple, reference pixel
// memory and a read scoreboard keyed on return cycle and master.
module tb_demosaic_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [2:0]  m0_be, m1_be;
    logic [13:0] m0_addr, m1_addr;
    logic [23:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [23:0] m0_rdata, m1_rdata;
    logic        wr_r, wr_g, wr_b;
    logic [13:0] addr_r, addr_g, addr_b;
    logic [7:0]  wdata_r, wdata_g, wdata_b;
    logic [7:0]  rdata_r, rdata_g, rdata_b;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        int          id;
        logic [23:0] data;
        int          due;
    } exp_t;
    exp_t q[$];

    // SRAM contents and reference contents; unwritten words read a pattern
    logic [7:0] sram_r [0:16383];
    logic [7:0] sram_g [0:16383];
    logic [7:0] sram_b [0:16383];
    bit         sv_r   [0:16383];
    bit         sv_g   [0:16383];
    bit         sv_b   [0:16383];
    logic [7:0] ref_r  [0:16383];
    logic [7:0] ref_g  [0:16383];
    logic [7:0] ref_b  [0:16383];
    bit         rv_r   [0:16383];
    bit         rv_g   [0:16383];
    bit         rv_b   [0:16383];

    demosaic_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_be(m0_be), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_be(m1_be), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b),
        .addr_r(addr_r), .addr_g(addr_g), .addr_b(addr_b),
        .wdata_r(wdata_r), .wdata_g(wdata_g), .wdata_b(wdata_b),
        .rdata_r(rdata_r), .rdata_g(rdata_g), .rdata_b(rdata_b)
    );

    function automatic logic [7:0] init_val(input int c, input int a);
        return 8'((a * 37 + c * 101 + (a >> 5)) & 255);
    endfunction

    function automatic logic [23:0] ref_word(input int a);
        return {rv_r[a] ? ref_r[a] : init_val(2, a),
                rv_g[a] ? ref_g[a] : init_val(1, a),
                rv_b[a] ? ref_b[a] : init_val(0, a)};
    endfunction

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous SRAM triple: read data one cycle after address, read-first
    always @(posedge clk) begin
        rdata_r <= sv_r[addr_r] ? sram_r[addr_r] : init_val(2, int'(addr_r));
        rdata_g <= sv_g[addr_g] ? sram_g[addr_g] : init_val(1, int'(addr_g));
        rdata_b <= sv_b[addr_b] ? sram_b[addr_b] : init_val(0, int'(addr_b));
        if (wr_r) begin sram_r[addr_r] <= wdata_r; sv_r[addr_r] <= 1'b1; end
        if (wr_g) begin sram_g[addr_g] <= wdata_g; sv_g[addr_g] <= 1'b1; end
        if (wr_b) begin sram_b[addr_b] <= wdata_b; sv_b[addr_b] <= 1'b1; end
    end

    // Scoreboard: pop on rvalid, push on accepted read beats, track writes
    always @(negedge clk) begin : mon
        int          gid;
        logic [23:0] gdat;
        exp_t        e;
        logic        bw;
        logic [2:0]  bbe;
        int          ba;
        logic [23:0] bd;
        if (reset === 1'b1) begin
            if (q.size() > 0 && q[0].due < cyc) begin
                n_cmp++; n_fail++;
                $display("FAIL rvalid_missing: no rvalid for M%0d at cycle %0d (now %0d)", q[0].id, q[0].due, cyc);
                e = q.pop_front();
            end
            if (m0_rvalid === 1'b1 && m1_rvalid === 1'b1) begin
                n_cmp++; n_fail++;
                $display("FAIL rvalid_both: both rvalid high at cycle %0d, expected at most one", cyc);
            end
            if (m0_rvalid === 1'b1 || m1_rvalid === 1'b1) begin
                gid  = (m1_rvalid === 1'b1) ? 1 : 0;
                gdat = (gid == 1) ? m1_rdata : m0_rdata;
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rvalid_unexpected: M%0d rvalid at cycle %0d data %h, expected none", gid, cyc, gdat);
                end else begin
                    e = q.pop_front();
                    if (e.id != gid || e.due != cyc || gdat !== e.data) begin
                        n_fail++;
                        $display("FAIL read_return: got M%0d cyc %0d data %h, expected M%0d cyc %0d data %h",
                                 gid, cyc, gdat, e.id, e.due, e.data);
                    end
                end
            end
            if (m0_gnt === 1'b1 && m1_gnt === 1'b1) begin
                n_cmp++; n_fail++;
                $display("FAIL double_grant: both gnt high at cycle %0d, expected one", cyc);
            end
            if (m0_gnt === 1'b1 || m1_gnt === 1'b1) begin
                gid = (m1_gnt === 1'b1) ? 1 : 0;
                bw  = gid ? m1_wr : m0_wr;
                bbe = gid ? m1_be : m0_be;
                ba  = int'(gid ? m1_addr : m0_addr);
                bd  = gid ? m1_wdata : m0_wdata;
                if (bw) begin
                    if (bbe[2]) begin ref_r[ba] <= bd[23:16]; rv_r[ba] <= 1'b1; end
                    if (bbe[1]) begin ref_g[ba] <= bd[15:8];  rv_g[ba] <= 1'b1; end
                    if (bbe[0]) begin ref_b[ba] <= bd[7:0];   rv_b[ba] <= 1'b1; end
                end else begin
                    e.id = gid; e.data = ref_word(ba); e.due = cyc + 2;
                    q.push_back(e);
                end
            end
        end
    end

    // Issue one beat from master m and wait (bounded) for its grant
    task automatic do_beat(input int m, input logic wr, input logic [2:0] be,
                           input logic [13:0] addr, input logic [23:0] wd, output int gcyc);
        bit got = 0;
        gcyc = -1;
        if (m == 0) begin m0_req = 1; m0_wr = wr; m0_be = be; m0_addr = addr; m0_wdata = wd; end
        else        begin m1_req = 1; m1_wr = wr; m1_be = be; m1_addr = addr; m1_wdata = wd; end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((m == 0 && m0_gnt === 1'b1) || (m == 1 && m1_gnt === 1'b1)) begin
                got = 1; gcyc = cyc; break;
            end
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL beat_timeout: M%0d no grant in 40 cycles, expected grant", m);
        end
        @(posedge clk); #1;
        if (m == 0) m0_req = 0; else m1_req = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({m0_gnt, m1_gnt} !== 2'b00) begin
                n_fail++; $display("FAIL reset_gnt[%0d]: got %b, expected 00", i, {m0_gnt, m1_gnt});
            end
            n_cmp++;
            if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
                n_fail++; $display("FAIL reset_rvalid[%0d]: got %b, expected 00", i, {m0_rvalid, m1_rvalid});
            end
            n_cmp++;
            if ({wr_r, wr_g, wr_b} !== 3'b000) begin
                n_fail++; $display("FAIL reset_wr[%0d]: got %b, expected 000", i, {wr_r, wr_g, wr_b});
            end
            n_cmp++;
            if ({addr_r, addr_g, addr_b, wdata_r, wdata_g, wdata_b} !== 66'd0) begin
                n_fail++; $display("FAIL reset_addr_wdata[%0d]: got %h, expected 0", i,
                                   {addr_r, addr_g, addr_b, wdata_r, wdata_g, wdata_b});
            end
        end
        @(posedge clk); #1;
        reset = 1; m0_req = 0; m1_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({m0_gnt, m1_gnt} !== 2'b00) begin
            n_fail++; $display("FAIL idle_gnt: got %b, expected 00", {m0_gnt, m1_gnt});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int  g;
        bit  seen = 0;
        do_beat(0, 1'b1, 3'b111, 14'h0081, 24'h102030, g);
        do_beat(0, 1'b0, 3'b000, 14'h0081, 24'h000000, g);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m0_rvalid === 1'b1) begin seen = 1; break; end
        end
        n_cmp++;
        if (!seen || cyc - g != 2) begin
            n_fail++; $display("FAIL rd_latency: seen=%0d after %0d cycles, expected 2", seen, cyc - g);
        end
        n_cmp++;
        if (m0_rdata !== 24'h102030) begin
            n_fail++; $display("FAIL rd_data: got %h, expected 102030", m0_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_byte_enable();
        int          g;
        bit          seen = 0;
        logic [23:0] want;
        want = {init_val(2, 5), 8'hAA, init_val(0, 5)};
        do_beat(0, 1'b1, 3'b010, 14'd5, {8'h11, 8'hAA, 8'h33}, g);
        @(negedge clk);
        n_cmp++;
        if ({wr_r, wr_g, wr_b} !== 3'b010) begin
            n_fail++; $display("FAIL be_wr: got %b, expected 010", {wr_r, wr_g, wr_b});
        end
        n_cmp++;
        if (addr_g !== 14'd5 || wdata_g !== 8'hAA) begin
            n_fail++; $display("FAIL be_addr_data: got addr %h data %h, expected 0005 aa", addr_g, wdata_g);
        end
        @(negedge clk);
        n_cmp++;
        if ({wr_r, wr_g, wr_b} !== 3'b000 || addr_g !== 14'd5) begin
            n_fail++; $display("FAIL be_hold: got wr %b addr %h, expected 000 0005", {wr_r, wr_g, wr_b}, addr_g);
        end
        @(posedge clk); #1;
        do_beat(0, 1'b0, 3'b111, 14'd5, 24'h0, g);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m0_rvalid === 1'b1) begin seen = 1; break; end
        end
        n_cmp++;
        if (!seen || m0_rdata !== want) begin
            n_fail++; $display("FAIL be_readback: seen=%0d got %h, expected %h", seen, m0_rdata, want);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int   idx = -1;
        int   first = -1;
        int   exp_own;
        logic g0, g1;
        m0_req = 1; m0_wr = 0; m0_be = 3'b111; m0_addr = 14'h1000; m0_wdata = '0;
        m1_req = 1; m1_wr = 0; m1_be = 3'b111; m1_addr = 14'h2000; m1_wdata = '0;
        for (int c = 0; c < 80 && idx < 64; c++) begin
            @(negedge clk);
            g0 = m0_gnt; g1 = m1_gnt;
            if (idx < 0 && (g0 === 1'b1 || g1 === 1'b1)) begin
                first = (g1 === 1'b1) ? 1 : 0; idx = 0;
            end
            if (idx >= 0) begin
                exp_own = first ^ ((idx / 16) & 1);
                n_cmp++;
                if ((g0 ^ g1) !== 1'b1 || int'(g1) != exp_own) begin
                    n_fail++; $display("FAIL burst_owner[%0d]: gnt0=%b gnt1=%b, expected owner M%0d", idx, g0, g1, exp_own);
                end
                idx++;
            end
            @(posedge clk); #1;
            if (g0 === 1'b1) m0_addr = m0_addr + 14'd1;
            if (g1 === 1'b1) m1_addr = m1_addr + 14'd1;
            if (idx >= 64) begin m0_req = 0; m1_req = 0; end
        end
        m0_req = 0; m1_req = 0;
        n_cmp++;
        if (first != 1) begin
            n_fail++; $display("FAIL rr_first_owner: got M%0d, expected M1", first);
        end
        repeat (4) @(posedge clk); #1;
    endtask

    task automatic test_long_burst();
        int   seen = 0;
        bit   broke = 0;
        bit   got = 0;
        int   wait_c = 0;
        logic g0;
        m0_req = 1; m0_wr = 1; m0_be = 3'b111; m0_addr = 14'h3000;
        m0_wdata = {8'h00, 8'hFF, 8'h5A};
        for (int c = 0; c < 110 && seen < 100; c++) begin
            @(negedge clk);
            g0 = m0_gnt;
            if (g0 === 1'b1) seen++; else if (seen > 0) broke = 1;
            @(posedge clk); #1;
            if (g0 === 1'b1) begin
                m0_addr  = m0_addr + 14'd1;
                m0_wdata = {m0_addr[7:0], ~m0_addr[7:0], m0_addr[7:0] ^ 8'h5A};
            end
        end
        n_cmp++;
        if (seen != 100 || broke) begin
            n_fail++; $display("FAIL solo_burst: got %0d grants (gap=%0d), expected 100 consecutive", seen, broke);
        end
        m1_req = 1; m1_wr = 0; m1_be = 3'b111; m1_addr = 14'h3000; m1_wdata = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            g0 = m0_gnt;
            if (m1_gnt === 1'b1) begin got = 1; wait_c = c; break; end
            @(posedge clk); #1;
            if (g0 === 1'b1) begin
                m0_addr  = m0_addr + 14'd1;
                m0_wdata = {m0_addr[7:0], ~m0_addr[7:0], m0_addr[7:0] ^ 8'h5A};
            end
        end
        @(posedge clk); #1;
        m0_req = 0; m1_req = 0;
        n_cmp++;
        if (!got || wait_c > 16) begin
            n_fail++; $display("FAIL handover_wait: got=%0d after %0d cycles, expected grant within 16", got, wait_c);
        end
        repeat (4) @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_read();
        int g;
        do_beat(0, 1'b0, 3'b111, 14'h0081, 24'h0, g);
        reset = 0;
        q.delete();
        @(posedge clk); #1;
        reset = 1; m0_req = 1; m0_wr = 0; m0_be = 3'b111; m0_addr = 14'h0081;
        @(negedge clk);
        n_cmp++;
        if (m0_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL dropped_read: got rvalid %b, expected 0", m0_rvalid);
        end
        n_cmp++;
        if (m0_gnt !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle: got gnt %b, expected 0", m0_gnt);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (m0_gnt !== 1'b1 || m0_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_grant: got gnt %b rvalid %b, expected 1 0", m0_gnt, m0_rvalid);
        end
        @(posedge clk); #1;
        m0_req = 0;
        repeat (4) @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0;
        m0_req = 1; m0_wr = 0; m0_be = 3'b000; m0_addr = '0; m0_wdata = '0;
        m1_req = 1; m1_wr = 0; m1_be = 3'b000; m1_addr = '0; m1_wdata = '0;
        test_reset();
        test_write_read();
        test_byte_enable();
        test_back_to_back();
        test_long_burst();
        test_reset_mid_read();
        repeat (8) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: %0d reads outstanding, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
